// File: rtl/coil_bank_emulator_if.sv
// Bridge-side bundle between a microstepper controller (master) and the coil emulator (slave).
interface coil_bank_emulator_if #(
    parameter int CHANNELS  = 2,
    parameter int CURRENT_W = 13,
    parameter int TW        = 13
);
    logic [2*CHANNELS-1:0]         s_h;
    logic [2*CHANNELS-1:0]         s_l;
    logic [CHANNELS-1:0]           pwm;
    logic [CHANNELS-1:0]           cmp;
    logic [CHANNELS*CURRENT_W-1:0] current;
    logic [CHANNELS*TW-1:0]        target;
    logic [CHANNELS-1:0]           fault;
    logic                          window_done;

    modport master (
        output s_h, s_l, pwm,
        input  cmp, current, target, fault, window_done
    );

    modport slave (
        input  s_h, s_l, pwm,
        output cmp, current, target, fault, window_done
    );
endinterface

// File: rtl/coil_bank_emulator.sv
// H-bridge coil current emulator with PWM duty recovery and delayed over-current comparator.
// Current responds one cycle after switch inputs, cmp lags by CMP_DELAY cycles; no backpressure.
module coil_bank_emulator #(
    parameter int CHANNELS   = 2,
    parameter int CURRENT_W  = 13,
    parameter int RISE       = 4,
    parameter int DECAY_SLOW = 1,
    parameter int DECAY_FAST = 6,
    parameter int PWM_PERIOD = 4096,
    parameter int CMP_DELAY  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    coil_bank_emulator_if.slave  bus
);
    localparam int TW = $clog2(PWM_PERIOD + 1);
    localparam int XW = CURRENT_W + 2;
    localparam int MW = (CURRENT_W > TW) ? CURRENT_W : TW;

    // Two guard bits so a step past full scale is seen before clamping.
    localparam logic signed [XW-1:0] MAX_X  = {3'b000, {(CURRENT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_X  = -MAX_X;
    localparam logic signed [XW-1:0] ZERO_X = '0;
    localparam logic signed [XW-1:0] RISE_X = XW'(RISE);
    localparam logic signed [XW-1:0] SLOW_X = XW'(DECAY_SLOW);
    localparam logic signed [XW-1:0] FAST_X = XW'(DECAY_FAST);

    logic signed [CURRENT_W-1:0] cur_q [CHANNELS];
    logic signed [CURRENT_W-1:0] cur_d [CHANNELS];
    logic [CHANNELS-1:0]         fault_q, fault_d;
    logic [TW-1:0]               win_q, win_d;
    logic [TW-1:0]               hi_q  [CHANNELS];
    logic [TW-1:0]               hi_d  [CHANNELS];
    logic [TW-1:0]               tgt_q [CHANNELS];
    logic [TW-1:0]               tgt_d [CHANNELS];
    logic                        wdone_q;
    logic                        last_cycle;
    logic [CHANNELS-1:0]         raw_cmp;
    logic [CHANNELS-1:0]         dly_q [CMP_DELAY];

    logic signed [XW-1:0] cx, nx, dec;
    logic                 h0, h1, l0, l1;
    logic [CURRENT_W-1:0] mag;

    always_comb begin
        cur_d   = cur_q;
        fault_d = fault_q;
        cx  = '0;
        nx  = '0;
        dec = '0;
        h0  = 1'b0;
        h1  = 1'b0;
        l0  = 1'b0;
        l1  = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            h0 = bus.s_h[2*c];
            h1 = bus.s_h[2*c+1];
            l0 = bus.s_l[2*c];
            l1 = bus.s_l[2*c+1];
            cx = XW'(cur_q[c]);
            nx = cx;
            dec = ((l0 & l1) | (h0 & h1)) ? SLOW_X : FAST_X;
            if ((h0 & l0) | (h1 & l1)) begin
                fault_d[c] = 1'b1;
            end else if (h0 & l1) begin
                nx = cx + RISE_X;
                if (nx > MAX_X) nx = MAX_X;
            end else if (h1 & l0) begin
                nx = cx - RISE_X;
                if (nx < MIN_X) nx = MIN_X;
            end else if (cx > ZERO_X) begin
                // Decay pulls toward zero and stops there rather than reversing.
                nx = cx - dec;
                if (nx < ZERO_X) nx = ZERO_X;
            end else if (cx < ZERO_X) begin
                nx = cx + dec;
                if (nx > ZERO_X) nx = ZERO_X;
            end
            cur_d[c] = nx[CURRENT_W-1:0];
        end
    end

    assign last_cycle = (win_q == TW'(PWM_PERIOD - 1));

    // The last-cycle pwm sample is folded into the closing window's result.
    always_comb begin
        win_d = last_cycle ? '0 : win_q + TW'(1);
        for (int c = 0; c < CHANNELS; c++) begin
            if (last_cycle) begin
                tgt_d[c] = hi_q[c] + TW'(bus.pwm[c]);
                hi_d[c]  = '0;
            end else begin
                tgt_d[c] = tgt_q[c];
                hi_d[c]  = hi_q[c] + TW'(bus.pwm[c]);
            end
        end
    end

    always_comb begin
        raw_cmp = '0;
        mag     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mag = cur_q[c][CURRENT_W-1] ? $unsigned(-cur_q[c]) : $unsigned(cur_q[c]);
            raw_cmp[c] = MW'(mag) > MW'(tgt_q[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fault_q <= '0;
            win_q   <= '0;
            wdone_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                cur_q[c] <= '0;
                hi_q[c]  <= '0;
                tgt_q[c] <= '0;
            end
            for (int i = 0; i < CMP_DELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            fault_q <= fault_d;
            win_q   <= win_d;
            wdone_q <= last_cycle;
            for (int c = 0; c < CHANNELS; c++) begin
                cur_q[c] <= cur_d[c];
                hi_q[c]  <= hi_d[c];
                tgt_q[c] <= tgt_d[c];
            end
            dly_q[0] <= raw_cmp;
            for (int i = 1; i < CMP_DELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    logic [CHANNELS*CURRENT_W-1:0] cur_flat;
    logic [CHANNELS*TW-1:0]        tgt_flat;

    always_comb begin
        cur_flat = '0;
        tgt_flat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cur_flat[c*CURRENT_W +: CURRENT_W] = cur_q[c];
            tgt_flat[c*TW +: TW]               = tgt_q[c];
        end
    end

    assign bus.current     = cur_flat;
    assign bus.target      = tgt_flat;
    assign bus.fault       = fault_q;
    assign bus.window_done = wdone_q;
    assign bus.cmp         = dly_q[CMP_DELAY-1];
endmodule

// File: doc/coil_bank_emulator.md
# coil_bank_emulator

Parametrised, synthesizable emulation of CHANNELS stepper-motor coils driven by H-bridges, for closed-loop simulation and FPGA hardware-in-the-loop testing of the microstepper. Each channel integrates a signed coil current from its four bridge-switch inputs, recovers the chopper's target current from its PWM reference output by duty-cycle measurement, and returns a delayed over-current comparator bit. It adds multi-channel scaling, signed current with saturation, separate slow/fast decay rates, sticky shoot-through fault capture and a configurable comparator latency.

## Interface

Parameters:
- CHANNELS, 2, number of coils/bridges.
- CURRENT_W, 13, signed current width per channel.
- RISE, 4, current increment per cycle while driving.
- DECAY_SLOW, 1, magnitude decrement per cycle in slow decay.
- DECAY_FAST, 6, magnitude decrement per cycle in fast decay.
- PWM_PERIOD, 4096, duty measurement window length in cycles (>=2).
- CMP_DELAY, 2, comparator output delay stages (>=1).

Ports (TW = clog2(PWM_PERIOD+1)):
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- s_h  in  2*CHANNELS  high-side gates; bits [2c+1:2c] = channel c half-bridges 0/1.
- s_l  in  2*CHANNELS  low-side gates, same packing.
- pwm  in  CHANNELS  per-channel PWM current reference from DUT.
- cmp  out  CHANNELS  per-channel comparator, 1 = |current| > target.
- current  out  CHANNELS*CURRENT_W  signed coil currents, channel c at [c*CURRENT_W +: CURRENT_W].
- target  out  CHANNELS*TW  last measured duty (high-cycle count) per channel.
- fault  out  CHANNELS  sticky shoot-through flag.
- window_done  out  1  one-cycle pulse when target values update.

## Operation

- Bridge decode per channel (priority order, evaluated every cycle):
  - Shoot-through: (h0&l0)|(h1&l1) -> fault[c] <= 1, current held.
  - Drive +: h0&l1 -> current += RISE.
  - Drive -: h1&l0 -> current -= RISE.
  - Slow decay: (l0&l1)|(h0&h1) -> magnitude reduced by DECAY_SLOW.
  - Fast decay: all four off, or any other combination -> magnitude reduced by DECAY_FAST.
- Saturation: current clamps to [-(2^(CURRENT_W-1)-1), +(2^(CURRENT_W-1)-1)]; most-negative code never produced.
- Decay clamps at 0; never crosses sign.
- fault[c] cleared only by reset.
- Duty measurement: shared window counter 0..PWM_PERIOD-1; per-channel high counter increments when pwm[c]=1. At counter = PWM_PERIOD-1: target[c] <= high_cnt[c] + pwm[c], high_cnt cleared, window_done = 1, counter wraps to 0.
- Comparator: raw = |current[c]| > target[c] (unsigned compare, magnitude zero-extended); raw registered then passed through CMP_DELAY-1 further stages.

## Timing

- Reset: current, target, cmp, fault, window_done, window counter, high counters, delay line all 0.
- Current: switch input at cycle n affects current at n+1.
- target/window_done: update registered at the end of cycle PWM_PERIOD-1 of each window; visible next cycle. First update PWM_PERIOD cycles after reset release.
- cmp: reflects current/target of cycle n at n+CMP_DELAY.
- Simultaneous shoot-through and drive codes: shoot-through wins.
- Window boundary: pwm sample on last window cycle counts toward the closing window, not the next.
- Reset mid-window: partial counts discarded; target returns to 0.

## Test plan

- Reset, all switches off, pwm=0 -> current=0, cmp=0, fault=0; after 4096 cycles target=0, window_done pulses once.
- Ch0 h0=l1=1 for 100 cycles -> current0=400; then all off 66 cycles -> 4, 67th cycle -> 0 and holds.
- Ch1 h1=l0=1 held 2100 cycles -> current1 reaches -4095 and saturates; then l0=l1=1 10 cycles -> -4085.
- pwm0 high 1024 of 4096 cycles -> target0=1024 after window; current0=1025 -> cmp0=1 exactly CMP_DELAY=2 cycles later; 1024 -> cmp0=0.
- Ch0 h0=l0=1 one cycle -> fault0=1, current0 unchanged; fault0 stays 1 after normal drive; clears only on resetn=0.
- resetn deasserted mid-window with pwm1 high -> first post-reset window reports target1=4096 with pwm1 held high; CHANNELS=4 build: channels independent, no cross-coupling.
